// File: rtl/banner_msg_writer.sv
// Write side of the rotating LED banner: double-buffered digit store with a
// valid/ready append port, atomic commit/clear, and a zero-latency read port.
module banner_msg_writer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_valid,
  input  logic [3:0]    wr_data,
  output logic          wr_ready,
  input  logic          commit,
  input  logic          clear,
  input  logic [AW-1:0] rd_addr,
  output logic [3:0]    rd_data,
  output logic [AW:0]   msg_len,
  output logic          msg_new,
  output logic          full
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL
  } stg_state_t;

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  stg_state_t  state;
  logic [AW:0] stg_cnt;
  logic [AW:0] eff_cnt;
  logic [AW:0] cnt_nxt;
  logic        bank_sel;
  logic        wr_acc;
  logic        do_swap;
  logic [3:0]  mem [2][DEPTH];

  function automatic stg_state_t decode(input logic [AW:0] cnt);
    if (cnt == '0)             return ST_EMPTY;
    else if (cnt == DEPTH_CNT) return ST_FULL;
    else                       return ST_FILLING;
  endfunction

  assign full     = (state == ST_FULL);
  assign wr_ready = ~full & ~clear;
  assign wr_acc   = wr_valid & wr_ready;
  // A digit accepted in the commit cycle belongs to the committed message.
  assign eff_cnt  = stg_cnt + {{AW{1'b0}}, wr_acc};
  assign do_swap  = commit & ~clear & (eff_cnt != '0);

  always_comb begin
    // NOTE: default first so every path assigns cnt_nxt and no latch is inferred.
    cnt_nxt = stg_cnt;
    if (clear || do_swap) cnt_nxt = '0;
    else if (wr_acc)      cnt_nxt = eff_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_cnt  <= '0;
      state    <= ST_EMPTY;
      msg_len  <= '0;
      bank_sel <= 1'b0;
      msg_new  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      stg_cnt <= cnt_nxt;
      state   <= decode(cnt_nxt);
      msg_new <= do_swap;
      if (do_swap) begin
        bank_sel <= ~bank_sel;
        msg_len  <= eff_cnt;
      end
    end
  end

  // NOTE: digit storage is deliberately not reset; msg_len masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[~bank_sel][stg_cnt[AW-1:0]] <= wr_data;
  end

  assign rd_data = ({1'b0, rd_addr} < msg_len) ? mem[bank_sel][rd_addr] : 4'hF;

endmodule

// File: tb/tb_banner_msg_writer.sv
// Directed bench for banner_msg_writer: a behavioural model pushes expected
// results to a scoreboard queue; DUT outputs are popped and compared.
module tb_banner_msg_writer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_valid;
  logic [3:0] wr_data;
  logic       wr_ready;
  logic       commit;
  logic       clear;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;
  logic [4:0] msg_len;
  logic       msg_new;
  logic       full;

  banner_msg_writer #(.DEPTH(16), .AW(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .commit   (commit),
    .clear    (clear),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .msg_len  (msg_len),
    .msg_new  (msg_new),
    .full     (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       nw;
    logic [4:0] len;
    logic       fl;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] rd_q[$];

  int checks = 0;
  int errors = 0;

  // Bench-side model of the staging and active banks.
  int         m_cnt = 0;
  int         m_len = 0;
  logic [3:0] m_stg [16];
  logic [3:0] m_act [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus (called at posedge+1), update the model, then
  // compare the registered outputs at the next posedge+1.
  task automatic step(input bit wv, input logic [3:0] d, input bit cm, input bit cl);
    bit   ready;
    bit   acc;
    int   eff;
    exp_t e;
    wr_valid = wv;
    wr_data  = d;
    commit   = cm;
    clear    = cl;
    ready = (m_cnt != 16) && !cl;
    acc   = wv && ready;
    eff   = m_cnt + (acc ? 1 : 0);
    #1 check("wr_ready", {31'd0, wr_ready}, {31'd0, ready});
    e.nw = 1'b0;
    if (acc) m_stg[m_cnt] = d;
    if (cl) begin
      m_cnt = 0;
    end else if (cm && eff > 0) begin
      m_act = m_stg;
      m_len = eff;
      m_cnt = 0;
      e.nw  = 1'b1;
    end else if (acc) begin
      m_cnt++;
    end
    e.len = 5'(m_len);
    e.fl  = (m_cnt == 16);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    commit   = 1'b0;
    clear    = 1'b0;
    e = exp_q.pop_front();
    check("msg_new", {31'd0, msg_new}, {31'd0, e.nw});
    check("msg_len", {27'd0, msg_len}, {27'd0, e.len});
    check("full", {31'd0, full}, {31'd0, e.fl});
  endtask

  // Sweep every read address against the model; ends realigned at posedge+1.
  task automatic check_reads();
    logic [3:0] exp;
    for (int a = 0; a < 16; a++) begin
      rd_q.push_back((a < m_len) ? m_act[a] : 4'hF);
      rd_addr = 4'(a);
      #1;
      exp = rd_q.pop_front();
      check($sformatf("rd_data[%0d]", a), {28'd0, rd_data}, {28'd0, exp});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst msg_len", {27'd0, msg_len}, 32'd0);
    check("rst msg_new", {31'd0, msg_new}, 32'd0);
    check("rst full", {31'd0, full}, 32'd0);
    check("rst wr_ready", {31'd0, wr_ready}, 32'd1);
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 4'h0;
    commit   = 1'b0;
    clear    = 1'b0;
    rd_addr  = 4'h0;
    for (int i = 0; i < 16; i++) begin
      m_stg[i] = 4'h0;
      m_act[i] = 4'h0;
    end

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    check_reads();
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Three digits then commit; msg_new must drop after one cycle.
    step(1, 4'h3, 0, 0);
    step(1, 4'h1, 0, 0);
    step(1, 4'h4, 0, 0);
    step(0, 4'h0, 1, 0);
    step(0, 4'h0, 0, 0);
    check_reads();

    // Staged digits stay invisible until commit.
    step(1, 4'h9, 0, 0);
    step(1, 4'h9, 0, 0);
    check_reads();
    step(0, 4'h0, 1, 0);
    check_reads();

    // Fill to DEPTH; the 17th write is dropped.
    for (int i = 0; i < 16; i++) step(1, 4'(i), 0, 0);
    step(1, 4'h7, 0, 0);
    step(0, 4'h0, 1, 0);
    check_reads();

    // Write in the commit cycle, clear beats commit, empty commit ignored.
    step(1, 4'h7, 1, 0);
    check_reads();
    step(1, 4'h5, 1, 1);
    step(0, 4'h0, 1, 0);
    check_reads();

    // Asynchronous reset mid-fill, asserted between clock edges.
    for (int i = 0; i < 5; i++) step(1, 4'(i + 2), 0, 0);
    #1 reset_n = 1'b0;
    #1;
    m_cnt = 0;
    m_len = 0;
    check_reset_outputs();
    check_reads();
    reset_n = 1'b1;
    step(0, 4'h0, 1, 0);
    check_reads();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
